// File: rtl/button_cmd_arbiter.sv
// Latches debounced key pulses as pending requests and issues them one at a time,
// round-robin, over a valid/ack handshake with a post-command cooldown.
module button_cmd_arbiter #(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int HOLD    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    pulse_in,
    input  logic            cmd_ack,
    output logic            cmd_valid,
    output logic [ID_W-1:0] cmd_id,
    output logic [N-1:0]    pending,
    output logic            busy,
    output logic            timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } state_t;

    localparam logic [7:0] HOLD_LOAD    = 8'(HOLD - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t          state, state_next;
    logic [7:0]      counter, counter_next;
    logic [ID_W-1:0] rr_last, rr_last_next;
    logic [ID_W-1:0] cmd_id_next;
    logic            cmd_valid_next;
    logic            timeout_err_next;
    logic [N-1:0]    clear_mask;
    logic [N-1:0]    pending_next;
    logic [ID_W-1:0] winner;
    logic            found;

    // Scan starts just past the last grant; N is a power of two so the
    // ID_W-bit sum wraps modulo N for free.
    always_comb begin
        logic [ID_W-1:0] idx;
        winner = rr_last;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = rr_last + ID_W'(k);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        counter_next     = counter;
        rr_last_next     = rr_last;
        cmd_id_next      = cmd_id;
        cmd_valid_next   = cmd_valid;
        timeout_err_next = 1'b0;
        clear_mask       = '0;

        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_next     = ST_ISSUE;
                    cmd_id_next    = winner;
                    cmd_valid_next = 1'b1;
                    rr_last_next   = winner;
                    clear_mask     = N'(1) << winner;
                    counter_next   = 8'd0;
                end
            end
            ST_ISSUE: begin
                // Ack wins over a timeout that lands in the same cycle.
                if (cmd_ack || counter == TIMEOUT_LAST) begin
                    cmd_valid_next   = 1'b0;
                    timeout_err_next = !cmd_ack;
                    if (HOLD == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_HOLD;
                        counter_next = HOLD_LOAD;
                    end
                end else begin
                    counter_next = counter + 8'd1;
                end
            end
            ST_HOLD: begin
                if (counter == 8'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    counter_next = counter - 8'd1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                cmd_valid_next = 1'b0;
            end
        endcase
    end

    // A pulse on the bit being granted re-sets it: set has priority over clear.
    assign pending_next = (pending & ~clear_mask) | pulse_in;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            counter     <= 8'd0;
            rr_last     <= ID_W'(N - 1);
            cmd_id      <= '0;
            cmd_valid   <= 1'b0;
            timeout_err <= 1'b0;
            pending     <= '0;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            rr_last     <= rr_last_next;
            cmd_id      <= cmd_id_next;
            cmd_valid   <= cmd_valid_next;
            timeout_err <= timeout_err_next;
            pending     <= pending_next;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Directed and randomized checks of button_cmd_arbiter against a behavioural model,
// on two instances: HOLD=8/TIMEOUT=255 and HOLD=0/TIMEOUT=5.
module tb_button_cmd_arbiter;

    localparam int N       = 4;
    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_HOLD  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pulse_in;
    logic       cmd_ack;
    logic [1:0] valid;
    logic [1:0] busy;
    logic [1:0] terr;
    logic [1:0] id   [2];
    logic [3:0] pend [2];

    int checks = 0;
    int errors = 0;

    int hold_p [2] = '{8, 0};
    int to_p   [2] = '{255, 5};
    int m_phase [2];
    int m_pend  [2];
    int m_last  [2];
    int m_id    [2];
    int m_wait  [2];
    int m_hleft [2];
    int m_terr  [2];
    int exp_order [4] = '{0, 1, 2, 3};

    always #5 clk = ~clk;

    button_cmd_arbiter #(.N(4), .ID_W(2), .HOLD(8), .TIMEOUT(255)) u_dut0 (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .cmd_ack(cmd_ack),
        .cmd_valid(valid[0]), .cmd_id(id[0]), .pending(pend[0]),
        .busy(busy[0]), .timeout_err(terr[0])
    );

    button_cmd_arbiter #(.N(4), .ID_W(2), .HOLD(0), .TIMEOUT(5)) u_dut1 (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .cmd_ack(cmd_ack),
        .cmd_valid(valid[1]), .cmd_id(id[1]), .pending(pend[1]),
        .busy(busy[1]), .timeout_err(terr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_phase[m] = P_IDLE;
            m_pend[m]  = 0;
            m_last[m]  = N - 1;
            m_id[m]    = 0;
            m_wait[m]  = 0;
            m_hleft[m] = 0;
            m_terr[m]  = 0;
        end
    endtask

    // One clock edge of the arbiter as described in words: grant, wait for ack
    // or give up, then sit out the cooldown.
    task automatic model_update(input int p, input int a);
        for (int m = 0; m < 2; m++) begin
            int gmask;
            bit found;
            gmask     = 0;
            found     = 0;
            m_terr[m] = 0;
            case (m_phase[m])
                P_IDLE: begin
                    if (m_pend[m] != 0) begin
                        for (int i = 1; i <= N; i++) begin
                            int c;
                            c = (m_last[m] + i) % N;
                            if (!found && ((m_pend[m] >> c) & 1) == 1) begin
                                found = 1;
                                m_id[m] = c;
                            end
                        end
                        m_last[m]  = m_id[m];
                        gmask      = 1 << m_id[m];
                        m_phase[m] = P_ISSUE;
                        m_wait[m]  = 0;
                    end
                end
                P_ISSUE: begin
                    if (a != 0 || m_wait[m] == to_p[m] - 1) begin
                        m_terr[m] = (a == 0);
                        if (hold_p[m] == 0) m_phase[m] = P_IDLE;
                        else begin
                            m_phase[m] = P_HOLD;
                            m_hleft[m] = hold_p[m];
                        end
                    end else begin
                        m_wait[m]++;
                    end
                end
                default: begin
                    m_hleft[m]--;
                    if (m_hleft[m] == 0) m_phase[m] = P_IDLE;
                end
            endcase
            m_pend[m] = (m_pend[m] & ~gmask) | p;
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("valid%0d", m), valid[m], (m_phase[m] == P_ISSUE));
            check($sformatf("id%0d", m), id[m], m_id[m]);
            check($sformatf("pending%0d", m), pend[m], m_pend[m]);
            check($sformatf("busy%0d", m), busy[m], (m_phase[m] != P_IDLE));
            check($sformatf("timeout_err%0d", m), terr[m], m_terr[m]);
        end
    endtask

    task automatic step();
        int p;
        int a;
        p = pulse_in;
        a = cmd_ack;
        @(posedge clk);
        model_update(p, a);
        #1;
        pulse_in = '0;
        cmd_ack  = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        pulse_in = '0;
        cmd_ack  = 1'b0;
        reset    = 1'b1;
        #2;
        model_reset();
        compare_all();
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int m);
        int n;
        n = 0;
        while (valid[m] !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check($sformatf("wait_valid%0d", m), valid[m], 1'b1);
    endtask

    initial begin
        int n;
        pulse_in = '0;
        cmd_ack  = 1'b0;
        reset    = 1'b0;
        #1;
        do_reset();

        // 1: asynchronous reset in the middle of a command
        pulse_in = 4'b0001;
        step();
        step();
        pulse_in = 4'b0110;
        step();
        check("t1_valid_before", valid[0], 1'b1);
        check("t1_pend_before", pend[0], 4'b0110);
        do_reset();
        check("t1_pend_reset", pend[0], 4'b0000);
        check("t1_valid_reset", valid[0], 1'b0);
        check("t1_busy_reset", busy[0], 1'b0);
        pulse_in = 4'b0100;
        step();
        step();
        check("t1_id_after", id[0], 2'd2);

        // 2: single request with an 8-cycle cooldown
        do_reset();
        pulse_in = 4'b0100;
        step();
        check("t2_pend_edge0", pend[0], 4'b0100);
        check("t2_valid_edge0", valid[0], 1'b0);
        step();
        check("t2_valid_edge1", valid[0], 1'b1);
        check("t2_id_edge1", id[0], 2'd2);
        check("t2_pend_edge1", pend[0], 4'b0000);
        step();
        step();
        cmd_ack = 1'b1;
        step();
        check("t2_valid_ack", valid[0], 1'b0);
        check("t2_id_hold", id[0], 2'd2);
        for (int i = 0; i < 7; i++) begin
            step();
            check("t2_busy_hold", busy[0], 1'b1);
        end
        step();
        check("t2_busy_done", busy[0], 1'b0);

        // 3: round-robin order
        do_reset();
        pulse_in = 4'b1111;
        step();
        for (int g = 0; g < 4; g++) begin
            wait_valid(0);
            check($sformatf("t3_grant%0d", g), id[0], exp_order[g]);
            cmd_ack = 1'b1;
            step();
        end
        pulse_in = 4'b1001;
        step();
        wait_valid(0);
        check("t3_second_a", id[0], 2'd0);
        cmd_ack = 1'b1;
        step();
        wait_valid(0);
        check("t3_second_b", id[0], 2'd3);
        cmd_ack = 1'b1;
        step();

        // 4: timeout without ack
        do_reset();
        pulse_in = 4'b0010;
        step();
        wait_valid(0);
        check("t4_id", id[0], 2'd1);
        n = 0;
        while (valid[0] === 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("t4_valid_width", n, 255);
        check("t4_timeout_err", terr[0], 1'b1);
        check("t4_pend_bit1", pend[0][1], 1'b0);
        check("t4_busy_hold", busy[0], 1'b1);
        step();
        check("t4_timeout_pulse", terr[0], 1'b0);

        // 5: set and clear on the same bit at the grant edge
        do_reset();
        pulse_in = 4'b0001;
        step();
        pulse_in = 4'b0001;
        step();
        check("t5_id", id[0], 2'd0);
        check("t5_pend_kept", pend[0][0], 1'b1);
        cmd_ack = 1'b1;
        step();
        wait_valid(0);
        check("t5_regrant", id[0], 2'd0);
        cmd_ack = 1'b1;
        step();

        // 6: zero cooldown, pulses latched while busy, stray ack in idle
        do_reset();
        pulse_in = 4'b0001;
        step();
        wait_valid(1);
        pulse_in = 4'b0100;
        step();
        pulse_in = 4'b1000;
        cmd_ack  = 1'b1;
        step();
        check("t6_valid_ack", valid[1], 1'b0);
        check("t6_busy_ack", busy[1], 1'b0);
        check("t6_pend_ack", pend[1], 4'b1100);
        step();
        check("t6_valid_next", valid[1], 1'b1);
        check("t6_id_next", id[1], 2'd2);
        cmd_ack = 1'b1;
        step();
        step();
        check("t6_id_last", id[1], 2'd3);
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b1;
        step();
        check("t6_idle_ack_valid", valid[1], 1'b0);
        check("t6_idle_ack_busy", busy[1], 1'b0);
        check("t6_idle_ack_pend", pend[1], 4'b0000);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) pulse_in = 4'($urandom);
            cmd_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
